// File: rtl/bcd_counter_mux_display.sv
// Multi-decade up/down BCD event counter with a time-multiplexed common-anode
// seven-segment scan. Optional macro: BCD_LEADING_ZERO_BLANK_EN.
module bcd_counter_mux_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pulse,
    input  logic        up_down,
    input  logic        clear,
    output logic [15:0] count_bcd,
    output logic        carry_out,
    output logic [7:0]  seven_segment_data,
    output logic [3:0]  seven_segment_enable
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [1:0]       SEL_LAST = 2'(NUM_DIGITS - 1);

    logic [15:0]      count_q, count_d;
    logic             carry_q, carry_d;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             ripple;
    logic [3:0]       selNibble;
    logic [7:0]       segData;

    function automatic logic [7:0] segDecode(input logic [3:0] nibble);
        case (nibble)
            4'd1:    segDecode = 8'hF9;
            4'd2:    segDecode = 8'hA4;
            4'd3:    segDecode = 8'hB0;
            4'd4:    segDecode = 8'h99;
            4'd5:    segDecode = 8'h92;
            4'd6:    segDecode = 8'h82;
            4'd7:    segDecode = 8'hF8;
            4'd8:    segDecode = 8'h80;
            4'd9:    segDecode = 8'h90;
            default: segDecode = 8'hC0;
        endcase
    endfunction

    // Carry/borrow ripples through every decade in one cycle; the ripple flag
    // surviving past the top decade means the whole range wrapped.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        ripple  = 1'b1;
        if (clear) begin
            count_d = '0;
        end else if (pulse) begin
            for (int i = 0; i < 4; i++) begin
                if (i < NUM_DIGITS && ripple) begin
                    if (up_down) begin
                        if (count_q[4*i +: 4] >= 4'd9) begin
                            count_d[4*i +: 4] = 4'd0;
                        end else begin
                            count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                            ripple = 1'b0;
                        end
                    end else begin
                        if (count_q[4*i +: 4] == 4'd0 || count_q[4*i +: 4] > 4'd9) begin
                            count_d[4*i +: 4] = 4'd9;
                        end else begin
                            count_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                            ripple = 1'b0;
                        end
                    end
                end
            end
            carry_d = ripple;
        end
    end

    always_comb begin
        divCnt_d = divCnt_q + DIV_W'(1);
        sel_d    = sel_q;
        if (divCnt_q == DIV_LAST) begin
            divCnt_d = '0;
            sel_d    = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            divCnt_q <= '0;
            sel_q    <= 2'd0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            divCnt_q <= divCnt_d;
            sel_q    <= sel_d;
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [1:0] topNonZero;
`endif

    // Decode is combinational so the display tracks count_bcd in the same cycle.
    always_comb begin
        selNibble = count_q[{sel_q, 2'b00} +: 4];
        segData   = segDecode(selNibble);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        topNonZero = 2'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (count_q[4*i +: 4] != 4'd0) topNonZero = 2'(i);
        end
        if (sel_q > topNonZero) segData = 8'hFF;
`endif
    end

    always_comb begin
        seven_segment_enable        = 4'hF;
        seven_segment_enable[sel_q] = 1'b0;
    end

    assign count_bcd          = count_q;
    assign carry_out          = carry_q;
    assign seven_segment_data = segData;

endmodule

// File: tb/tb_bcd_counter_mux_display.sv
// Scoreboard bench: two counters (4 and 2 decades, SCAN_DIV=4) share stimulus
// and are checked against an integer-arithmetic reference model.
module tb_bcd_counter_mux_display;

    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pulse = 1'b0;
    logic up_down = 1'b1;
    logic clear = 1'b0;

    logic [15:0] cnt4, cnt2;
    logic        c4, c2;
    logic [7:0]  d4, d2;
    logic [3:0]  e4, e2;

    int errors = 0;
    int checks = 0;

    bcd_counter_mux_display #(.NUM_DIGITS(4), .SCAN_DIV(SD)) dut4 (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .up_down(up_down), .clear(clear),
        .count_bcd(cnt4), .carry_out(c4),
        .seven_segment_data(d4), .seven_segment_enable(e4));

    bcd_counter_mux_display #(.NUM_DIGITS(2), .SCAN_DIV(SD)) dut2 (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .up_down(up_down), .clear(clear),
        .count_bcd(cnt2), .carry_out(c2),
        .seven_segment_data(d2), .seven_segment_enable(e2));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cnt4; logic c4; logic [7:0] d4; logic [3:0] e4;
        logic [15:0] cnt2; logic c2; logic [7:0] d2; logic [3:0] e2;
    } expect_t;

    expect_t expQ[$];
    logic    monEn = 1'b0;

    logic [7:0] segTab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int val4 = 0;
    int val2 = 0;
    int edges = 0;

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] expData(input int v, input int sel);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (sel > 0 && v < pow10(sel)) return 8'hFF;
`endif
        return segTab[(v / pow10(sel)) % 10];
    endfunction

    function automatic logic [3:0] expEnable(input int sel);
        logic [3:0] r;
        r = 4'hF;
        r[sel] = 1'b0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Called at a negedge: drive one cycle of inputs, advance the model to the
    // state after the coming posedge and queue what the DUTs should show then.
    task automatic applyStimulus(input logic p, input logic ud, input logic clr);
        expect_t e;
        int sel;
        logic w4, w2;
        pulse   = p;
        up_down = ud;
        clear   = clr;
        w4 = 1'b0;
        w2 = 1'b0;
        if (clr) begin
            val4 = 0;
            val2 = 0;
        end else if (p) begin
            if (ud) begin
                w4 = (val4 == 9999);
                w2 = (val2 == 99);
                val4 = (val4 + 1) % 10000;
                val2 = (val2 + 1) % 100;
            end else begin
                w4 = (val4 == 0);
                w2 = (val2 == 0);
                val4 = (val4 + 9999) % 10000;
                val2 = (val2 + 99) % 100;
            end
        end
        edges++;
        sel    = (edges / SD) % 4;
        e.cnt4 = toBcd(val4);
        e.c4   = w4;
        e.d4   = expData(val4, sel);
        e.e4   = expEnable(sel);
        sel    = (edges / SD) % 2;
        e.cnt2 = toBcd(val2);
        e.c2   = w2;
        e.d2   = expData(val2, sel);
        e.e2   = expEnable(sel);
        expQ.push_back(e);
        @(negedge clk);
    endtask

    // Called at a negedge; asserts reset mid-cycle to exercise its asynchronous path.
    task automatic doReset();
        monEn = 1'b0;
        expQ.delete();
        pulse = 1'b0;
        clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_cnt4", cnt4, 16'h0000);
        checkOutput("rst_carry4", {15'd0, c4}, 16'd0);
        checkOutput("rst_en4", {12'd0, e4}, 16'h000E);
        checkOutput("rst_data4", {8'd0, d4}, 16'h00C0);
        checkOutput("rst_cnt2", cnt2, 16'h0000);
        checkOutput("rst_en2", {12'd0, e2}, 16'h000E);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        val4  = 0;
        val2  = 0;
        edges = 0;
        monEn = 1'b1;
    endtask

    // Monitor: compare the oldest expectation once outputs settle after each edge.
    always @(posedge clk) begin
        expect_t e;
        #1;
        if (monEn) begin
            if (expQ.size() == 0) begin
                checkOutput("queue_empty", 16'd0, 16'd1);
            end else begin
                e = expQ.pop_front();
                checkOutput("cnt4", cnt4, e.cnt4);
                checkOutput("carry4", {15'd0, c4}, {15'd0, e.c4});
                checkOutput("data4", {8'd0, d4}, {8'd0, e.d4});
                checkOutput("en4", {12'd0, e4}, {12'd0, e.e4});
                checkOutput("cnt2", cnt2, e.cnt2);
                checkOutput("carry2", {15'd0, c2}, {15'd0, e.c2});
                checkOutput("data2", {8'd0, d2}, {8'd0, e.d2});
                checkOutput("en2", {12'd0, e2}, {12'd0, e.e2});
            end
        end
    end

    initial begin
        @(negedge clk);
        doReset();
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0);

        // Ripple 1099 -> 1100
        repeat (1100) applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

        // Full-range wrap both directions from zero
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Clear beats pulse
        repeat (42) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);

        // Hold 0305 across two display frames
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (305) applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (32) applyStimulus(1'b0, 1'b0, 1'b0);

        // Blank-capable display at zero
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (16) applyStimulus(1'b0, 1'b0, 1'b0);

        // Random traffic, with an asynchronous reset in the middle
        repeat (1500) applyStimulus(1'(($urandom % 10) < 7), 1'($urandom), 1'(($urandom % 50) == 0));
        doReset();
        repeat (1500) applyStimulus(1'(($urandom % 10) < 7), 1'($urandom % 4 != 0), 1'(($urandom % 80) == 0));

        monEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
